ram_dp_clr: RTL and testbench

//  Parametrised dual-port synchronous RAM: successor to the fixed-size 1K/16K/32K blocks.

---
 rtl/ram_dp_clr.sv | 98 +++++++++
 tb/tb_ram_dp_clr.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/ram_dp_clr.sv
// Dual-port synchronous RAM. Port A reads and writes, port B only reads.
// A built-in sequencer fills every word with CLEAR_VALUE after reset or when clr_req is pulsed.
module ram_dp_clr #(
  parameter int              AW             = 10,
  parameter int              DW             = 8,
  parameter bit              CLEAR_ON_RESET = 1'b1,
  parameter logic [DW-1:0]   CLEAR_VALUE    = '0,
  parameter bit              RDW_MODE       = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_req,
  output logic          busy,
  input  logic          ce_a,
  input  logic          we_a,
  input  logic [AW-1:0] a_a,
  input  logic [DW-1:0] din_a,
  output logic [DW-1:0] dout_a,
  input  logic          ce_b,
  input  logic [AW-1:0] a_b,
  output logic [DW-1:0] dout_b
);

  localparam logic [0:0]  ST_READY = 1'b0;
  localparam logic [0:0]  ST_CLEAR = 1'b1;
  localparam int          DEPTH    = 2 ** AW;
  localparam logic [AW:0] CNT_LAST = {1'b0, {AW{1'b1}}};

  logic [DW-1:0] mem [DEPTH];

  logic [0:0]    state;
  logic [AW:0]   count;
  logic          clearing;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_a_en;

  assign clearing = (state == ST_CLEAR);
  assign busy     = clearing;

  // The clear sequencer takes over the single write port; port A is locked out meanwhile.
  // Writes are also held off while reset is asserted so reset never disturbs contents.
  assign wr_en   = rst_n && (clearing || (ce_a && we_a));
  assign wr_addr = clearing ? count[AW-1:0] : a_a;
  assign wr_data = clearing ? CLEAR_VALUE : din_a;
  assign rd_a_en = !clearing && ce_a;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
      count <= '0;
    end else begin
      case (state)
        ST_READY: begin
          count <= '0;
          if (clr_req) state <= ST_CLEAR;
        end
        ST_CLEAR: begin
          if (count == CNT_LAST) begin
            state <= ST_READY;
            count <= '0;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: begin
          state <= ST_READY;
          count <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Port A: registered read; in write-through mode a write forwards din_a instead of the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_a <= '0;
    end else if (rd_a_en) begin
      if (RDW_MODE && we_a) dout_a <= din_a;
      else                  dout_a <= mem[a_a];
    end
  end

  // Port B always sees the pre-write word on an address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_b <= '0;
    end else if (ce_b) begin
      dout_b <= mem[a_b];
    end
  end

endmodule

// File: tb/tb_ram_dp_clr.sv
// Directed bench for ram_dp_clr: three instances (old-data, write-through, no clear on reset)
// share one stimulus stream; each step checks outputs 1 time unit after the rising edge.
module tb_ram_dp_clr;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr_req;
  logic       ce_a, we_a, ce_b;
  logic [3:0] a_a, a_b;
  logic [7:0] din_a;

  logic       busy0, busy1, busy2;
  logic [7:0] dout_a0, dout_a1, dout_a2;
  logic [7:0] dout_b0, dout_b1, dout_b2;

  int checks   = 0;
  int failures = 0;
  int n;

  always #5 clk = ~clk;

  ram_dp_clr #(.AW(4), .DW(8), .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(8'hA5), .RDW_MODE(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy0),
    .ce_a(ce_a), .we_a(we_a), .a_a(a_a), .din_a(din_a), .dout_a(dout_a0),
    .ce_b(ce_b), .a_b(a_b), .dout_b(dout_b0));

  ram_dp_clr #(.AW(4), .DW(8), .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(8'hA5), .RDW_MODE(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy1),
    .ce_a(ce_a), .we_a(we_a), .a_a(a_a), .din_a(din_a), .dout_a(dout_a1),
    .ce_b(ce_b), .a_b(a_b), .dout_b(dout_b1));

  ram_dp_clr #(.AW(4), .DW(8), .CLEAR_ON_RESET(1'b0), .CLEAR_VALUE(8'hA5), .RDW_MODE(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy2),
    .ce_a(ce_a), .we_a(we_a), .a_a(a_a), .din_a(din_a), .dout_a(dout_a2),
    .ce_b(ce_b), .a_b(a_b), .dout_b(dout_b2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; clr_req = 1'b0;
    ce_a = 1'b0; we_a = 1'b0; a_a = '0; din_a = '0;
    ce_b = 1'b0; a_b = '0;

    // Reset state
    step; step; step;
    check("rst_dout_a", 32'(dout_a0), 32'h00);
    check("rst_dout_b", 32'(dout_b0), 32'h00);
    check("rst_busy_clr_on", 32'(busy0), 32'h1);
    check("rst_busy_clr_off", 32'(busy2), 32'h0);

    // Release reset away from the edge; count busy samples while the clear runs.
    // The no-clear instance is ready at once: write then read back 5A @15.
    rst_n = 1'b1;
    n = 0;
    while (busy0 && n < 100) begin
      if (n == 0) begin ce_a = 1'b1; we_a = 1'b1; a_a = 4'd15; din_a = 8'h5A; end
      if (n == 1) begin we_a = 1'b0; end
      if (n == 2) begin
        check("noclr_readback15", 32'(dout_a2), 32'h5A);
        check("clear_port_a_ignored", 32'(dout_a0), 32'h00);
        ce_a = 1'b0;
      end
      n++;
      step;
    end
    check("reset_clear_cycles", 32'(n), 32'd16);
    check("busy1_after_clear", 32'(busy1), 32'h0);

    // Every word holds the fill value on both ports
    ce_a = 1'b1; ce_b = 1'b1;
    for (int i = 0; i < 16; i++) begin
      a_a = 4'(i); a_b = 4'(15 - i);
      step;
      check($sformatf("fill_a[%0d]", i), 32'(dout_a0), 32'hA5);
      check($sformatf("fill_b[%0d]", 15 - i), 32'(dout_b0), 32'hA5);
    end

    // Write 3C @4 then read it on both ports
    ce_b = 1'b0; we_a = 1'b1; a_a = 4'd4; din_a = 8'h3C;
    step;
    check("wr4_rdw_old", 32'(dout_a0), 32'hA5);
    check("wr4_rdw_new", 32'(dout_a1), 32'h3C);
    we_a = 1'b0; ce_b = 1'b1; a_b = 4'd4;
    step;
    check("rd4_a", 32'(dout_a0), 32'h3C);
    check("rd4_b", 32'(dout_b0), 32'h3C);
    // ce_a low: output holds and a stray we_a does nothing
    ce_a = 1'b0; we_a = 1'b1; a_a = 4'd0; din_a = 8'hFF; ce_b = 1'b0;
    step;
    check("ce_a_low_hold", 32'(dout_a0), 32'h3C);
    ce_a = 1'b1; we_a = 1'b0;
    step;
    check("we_without_ce", 32'(dout_a0), 32'hA5);

    // Same-cycle write 77 @2 with port B reading @2
    we_a = 1'b1; a_a = 4'd2; din_a = 8'h77; ce_b = 1'b1; a_b = 4'd2;
    step;
    check("coll_b_old0", 32'(dout_b0), 32'hA5);
    check("coll_a_old", 32'(dout_a0), 32'hA5);
    check("coll_a_new", 32'(dout_a1), 32'h77);
    check("coll_b_old1", 32'(dout_b1), 32'hA5);
    we_a = 1'b0;
    step;
    check("after_coll_a", 32'(dout_a0), 32'h77);
    check("after_coll_b", 32'(dout_b0), 32'h77);

    // Requested clear; port A hammers addr 0 and a second request arrives mid-clear
    ce_a = 1'b0; ce_b = 1'b0; clr_req = 1'b1;
    step;
    clr_req = 1'b0;
    check("clr_req_busy", 32'(busy0), 32'h1);
    n = 0;
    while (busy0 && n < 100) begin
      if (n >= 1) begin ce_a = 1'b1; we_a = 1'b1; a_a = 4'd0; din_a = 8'hEE; end
      clr_req = (n == 5);
      if (n == 8) check("clear_dout_a_frozen", 32'(dout_a0), 32'h77);
      n++;
      step;
    end
    ce_a = 1'b0; we_a = 1'b0; clr_req = 1'b0;
    check("req_clear_cycles", 32'(n), 32'd16);
    check("post_clear_dout_a", 32'(dout_a0), 32'h77);
    ce_a = 1'b1; a_a = 4'd0; ce_b = 1'b1; a_b = 4'd2;
    step;
    check("addr0_not_written", 32'(dout_a0), 32'hA5);
    check("addr2_cleared", 32'(dout_b0), 32'hA5);
    ce_a = 1'b0; ce_b = 1'b0;

    // Reset at clear cycle 7 forces outputs to zero and restarts a full clear
    clr_req = 1'b1;
    step;
    clr_req = 1'b0;
    n = 0;
    while (n < 7) begin
      n++;
      step;
    end
    rst_n = 1'b0;
    #1;
    check("midclr_rst_dout_a", 32'(dout_a0), 32'h00);
    check("midclr_rst_dout_b", 32'(dout_b0), 32'h00);
    check("midclr_rst_busy", 32'(busy0), 32'h1);
    step;
    rst_n = 1'b1;
    n = 0;
    while (busy0 && n < 100) begin
      n++;
      step;
    end
    check("restart_clear_cycles", 32'(n), 32'd16);
    ce_a = 1'b1; a_a = 4'd15; ce_b = 1'b1; a_b = 4'd7;
    step;
    check("restart_fill_a15", 32'(dout_a0), 32'hA5);
    check("restart_fill_b7", 32'(dout_b0), 32'hA5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
